// File: rtl/xalu_pkg.sv
// Shared definitions for the nibble-serial ALU sequencer: function codes,
// sequencer states and small decode helpers.
package xalu_pkg;

    // Function codes presented on op_fn and forwarded to the slice on sl_f.
    typedef enum logic [2:0] {
        FnAdd   = 3'd0,
        FnAnd   = 3'd1,
        FnOr    = 3'd2,
        FnXor   = 3'd3,
        FnPassA = 3'd4,
        FnPassB = 3'd5,
        FnShr   = 3'd6,
        FnShl   = 3'd7
    } xalu_fn_e;

    // Sequencer states.
    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StDone = 2'd2
    } xalu_state_e;

    // Functions whose carry ripples leftwards (LSB pass toward MSB pass).
    function automatic logic fn_chains_left(input xalu_fn_e fn);
        return (fn == FnAdd) || (fn == FnShl);
    endfunction

    // Functions walked MSB nibble first, carry rippling rightwards.
    function automatic logic fn_chains_right(input xalu_fn_e fn);
        return (fn == FnShr);
    endfunction

endpackage

// File: rtl/xalu_nibble_sel.sv
// Picks the operand nibbles for the current pass; the pass index is mapped to
// a nibble position according to the walking direction.
module xalu_nibble_sel
    import xalu_pkg::*;
#(
    parameter int unsigned NIBBLES = 4,
    parameter int unsigned IDX_W   = 2
) (
    input  logic [4*NIBBLES-1:0] i_a,
    input  logic [4*NIBBLES-1:0] i_b,
    input  logic [IDX_W-1:0]     i_idx,
    input  logic                 i_msb_first,
    output logic [3:0]           o_a_nib,
    output logic [3:0]           o_b_nib,
    output logic [IDX_W-1:0]     o_pos
);

    localparam logic [IDX_W-1:0] LastIdx = IDX_W'(NIBBLES - 1);

    logic [IDX_W+1:0] w_bit_base;

    // MSB-first walking reverses the pass index.
    assign o_pos      = i_msb_first ? (LastIdx - i_idx) : i_idx;
    assign w_bit_base = {o_pos, 2'b00};
    assign o_a_nib    = i_a[w_bit_base +: 4];
    assign o_b_nib    = i_b[w_bit_base +: 4];

endmodule

// File: rtl/xalu_nibble_seq.sv
// Nibble-serial ALU sequencer: accepts a full-width operation, drives an
// external 4-bit ALU slice once per nibble while chaining the carry through a
// register, and assembles the full-width result and flags.
module xalu_nibble_seq
    import xalu_pkg::*;
#(
    parameter int unsigned NIBBLES = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    // Operation request
    input  logic                 op_valid,
    output logic                 op_ready,
    input  logic [4*NIBBLES-1:0] op_a,
    input  logic [4*NIBBLES-1:0] op_b,
    input  logic [2:0]           op_fn,
    input  logic                 op_com,
    input  logic                 op_cin,
    // External slice
    output logic [3:0]           sl_a,
    output logic [3:0]           sl_b,
    output logic [2:0]           sl_f,
    output logic                 sl_com,
    output logic                 sl_ci_right,
    output logic                 sl_ci_left,
    input  logic [3:0]           sl_d,
    input  logic                 sl_co_left,
    input  logic                 sl_co_right,
    input  logic                 sl_equ,
    input  logic                 sl_zero,
    // Result
    output logic                 res_valid,
    input  logic                 res_ready,
    output logic [4*NIBBLES-1:0] res_d,
    output logic                 res_carry,
    output logic                 res_zero,
    output logic                 res_equ
);

    localparam int unsigned W     = 4 * NIBBLES;
    localparam int unsigned IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IDX_W-1:0] LastIdx = IDX_W'(NIBBLES - 1);

    xalu_state_e      r_state;
    xalu_state_e      w_state_next;
    logic [IDX_W-1:0] r_idx;
    logic [W-1:0]     r_a;
    logic [W-1:0]     r_b;
    xalu_fn_e         r_fn;
    logic             r_com;
    logic             r_cin;
    logic             r_carry;
    logic [W-1:0]     r_res_d;
    logic             r_zero;
    logic             r_equ;

    logic             w_accept;
    logic             w_run;
    logic             w_last;
    logic             w_ci;
    logic             w_co;
    logic [3:0]       w_a_nib;
    logic [3:0]       w_b_nib;
    logic [IDX_W-1:0] w_pos;
    logic [IDX_W+1:0] w_bit_base;

    xalu_nibble_sel #(
        .NIBBLES (NIBBLES),
        .IDX_W   (IDX_W)
    ) u_sel (
        .i_a         (r_a),
        .i_b         (r_b),
        .i_idx       (r_idx),
        .i_msb_first (fn_chains_right(r_fn)),
        .o_a_nib     (w_a_nib),
        .o_b_nib     (w_b_nib),
        .o_pos       (w_pos)
    );

    // op_ready also drops while reset is held, not just once the state clears.
    assign op_ready   = rst_n && (r_state == StIdle);
    assign res_valid  = (r_state == StDone);
    assign w_accept   = (r_state == StIdle) && op_valid;
    assign w_run      = (r_state == StRun);
    assign w_last     = (r_idx == LastIdx);
    assign w_bit_base = {w_pos, 2'b00};

    // First pass takes the external carry/shift-in; later passes the chained one.
    assign w_ci = (r_idx == '0) ? r_cin : r_carry;

    // Carry-out worth keeping from this pass; zero for non-chaining functions.
    assign w_co = fn_chains_left(r_fn)  ? sl_co_left  :
                  fn_chains_right(r_fn) ? sl_co_right : 1'b0;

    assign res_d     = r_res_d;
    assign res_carry = r_carry;
    assign res_zero  = r_zero;
    assign res_equ   = r_equ;

    // Slice drive: everything held at zero unless a pass is in progress.
    always_comb begin
        sl_a        = '0;
        sl_b        = '0;
        sl_f        = '0;
        sl_com      = 1'b0;
        sl_ci_right = 1'b0;
        sl_ci_left  = 1'b0;
        if (w_run) begin
            sl_a   = w_a_nib;
            sl_b   = w_b_nib;
            sl_f   = r_fn;
            sl_com = r_com;
            if (fn_chains_left(r_fn)) begin
                sl_ci_right = w_ci;
            end
            if (fn_chains_right(r_fn)) begin
                sl_ci_left = w_ci;
            end
        end
    end

    // Next-state decode.
    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StIdle:  if (op_valid)  w_state_next = StRun;
            StRun:   if (w_last)    w_state_next = StDone;
            StDone:  if (res_ready) w_state_next = StIdle;
            default:                w_state_next = StIdle;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Operand latch, pass counter, carry chain and result accumulation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idx   <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_fn    <= FnAdd;
            r_com   <= 1'b0;
            r_cin   <= 1'b0;
            r_carry <= 1'b0;
            r_res_d <= '0;
            r_zero  <= 1'b0;
            r_equ   <= 1'b0;
        end else if (w_accept) begin
            r_idx   <= '0;
            r_a     <= op_a;
            r_b     <= op_b;
            r_fn    <= xalu_fn_e'(op_fn);
            r_com   <= op_com;
            r_cin   <= op_cin;
            r_carry <= 1'b0;
            // Flags are ANDed across passes, so start from all-true.
            r_zero  <= 1'b1;
            r_equ   <= 1'b1;
        end else if (w_run) begin
            r_res_d[w_bit_base +: 4] <= sl_d;
            r_carry <= w_co;
            r_zero  <= r_zero & sl_zero;
            r_equ   <= r_equ & sl_equ;
            r_idx   <= w_last ? '0 : r_idx + IDX_W'(1);
        end
    end

endmodule

// File: tb/tb_xalu_nibble_seq.sv
// Bench for xalu_nibble_seq: a behavioural 4-bit slice closes the loop and a
// word-level arithmetic model supplies the expected results.
module tb_xalu_nibble_seq;

    logic        clk;
    logic        rst_n;
    logic        op_valid;
    logic        op_ready;
    logic [15:0] op_a;
    logic [15:0] op_b;
    logic [2:0]  op_fn;
    logic        op_com;
    logic        op_cin;
    logic [3:0]  sl_a;
    logic [3:0]  sl_b;
    logic [2:0]  sl_f;
    logic        sl_com;
    logic        sl_ci_right;
    logic        sl_ci_left;
    logic [3:0]  sl_d;
    logic        sl_co_left;
    logic        sl_co_right;
    logic        sl_equ;
    logic        sl_zero;
    logic        res_valid;
    logic        res_ready;
    logic [15:0] res_d;
    logic        res_carry;
    logic        res_zero;
    logic        res_equ;

    int n_pass  = 0;
    int n_total = 0;

    xalu_nibble_seq #(
        .NIBBLES (4)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .op_valid    (op_valid),
        .op_ready    (op_ready),
        .op_a        (op_a),
        .op_b        (op_b),
        .op_fn       (op_fn),
        .op_com      (op_com),
        .op_cin      (op_cin),
        .sl_a        (sl_a),
        .sl_b        (sl_b),
        .sl_f        (sl_f),
        .sl_com      (sl_com),
        .sl_ci_right (sl_ci_right),
        .sl_ci_left  (sl_ci_left),
        .sl_d        (sl_d),
        .sl_co_left  (sl_co_left),
        .sl_co_right (sl_co_right),
        .sl_equ      (sl_equ),
        .sl_zero     (sl_zero),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .res_d       (res_d),
        .res_carry   (res_carry),
        .res_zero    (res_zero),
        .res_equ     (res_equ)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural 4-bit ALU slice.
    logic [4:0] m_sum;
    logic [3:0] m_raw;
    always_comb begin
        m_sum       = {1'b0, sl_a} + {1'b0, sl_b} + {4'b0, sl_ci_right};
        m_raw       = 4'h0;
        sl_co_left  = 1'b0;
        sl_co_right = 1'b0;
        case (sl_f)
            3'd0: begin m_raw = m_sum[3:0]; sl_co_left = m_sum[4]; end
            3'd1: m_raw = sl_a & sl_b;
            3'd2: m_raw = sl_a | sl_b;
            3'd3: m_raw = sl_a ^ sl_b;
            3'd4: m_raw = sl_a;
            3'd5: m_raw = sl_b;
            3'd6: begin m_raw = {sl_ci_left, sl_a[3:1]}; sl_co_right = sl_a[0]; end
            default: begin m_raw = {sl_a[2:0], sl_ci_right}; sl_co_left = sl_a[3]; end
        endcase
        sl_d    = sl_com ? ~m_raw : m_raw;
        sl_zero = (sl_d == 4'h0);
        sl_equ  = (sl_a == sl_b);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end else begin
            n_pass++;
        end
    endtask

    // Word-level reference: the whole operation as plain arithmetic.
    task automatic model(input logic [2:0] fn, input logic [15:0] a, input logic [15:0] b,
                         input logic com, input logic cin, output logic [15:0] r,
                         output logic c, output logic z, output logic e);
        logic [16:0] s;
        case (fn)
            3'd0: s = {1'b0, a} + {1'b0, b} + {16'b0, cin};
            3'd1: s = {1'b0, a & b};
            3'd2: s = {1'b0, a | b};
            3'd3: s = {1'b0, a ^ b};
            3'd4: s = {1'b0, a};
            3'd5: s = {1'b0, b};
            3'd6: s = {a[0], cin, a[15:1]};
            default: s = {a, cin};
        endcase
        r = com ? ~s[15:0] : s[15:0];
        c = (fn == 3'd0 || fn == 3'd6 || fn == 3'd7) ? s[16] : 1'b0;
        z = (r == 16'h0);
        e = (a == b);
    endtask

    task automatic scramble_inputs();
        op_a   = 16'($urandom);
        op_b   = 16'($urandom);
        op_fn  = 3'($urandom);
        op_com = 1'($urandom);
        op_cin = 1'($urandom);
    endtask

    // Runs one operation end to end; called and returns at a falling edge.
    task automatic run_op(input logic [2:0] fn, input logic [15:0] a, input logic [15:0] b,
                          input logic com, input logic cin, input int hold);
        logic [15:0] er;
        logic        ec, ez, ee;
        logic [15:0] seq;
        logic [15:0] eseq;
        int          n;
        model(fn, a, b, com, cin, er, ec, ez, ee);
        n = 0;
        while (!op_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("ready_wait", 32'(n < 20), 32'd1);
        op_valid = 1'b1;
        op_fn    = fn;
        op_a     = a;
        op_b     = b;
        op_com   = com;
        op_cin   = cin;
        @(negedge clk);
        // Accepted at the edge just passed; anything driven now must be ignored.
        op_valid = 1'($urandom);
        scramble_inputs();
        seq = 16'h0;
        n   = 0;
        while (!res_valid && n < 20) begin
            seq = {seq[11:0], sl_a};
            @(negedge clk);
            n++;
            op_valid = 1'($urandom);
            scramble_inputs();
        end
        check("latency", 32'(n), 32'd4);
        eseq = (fn == 3'd6) ? a : {a[3:0], a[7:4], a[11:8], a[15:12]};
        check("pass_order", 32'(seq), 32'(eseq));
        for (int i = 0; i < hold; i++) begin
            op_valid = 1'b1;
            scramble_inputs();
            check("hold_valid", 32'(res_valid), 32'd1);
            check("hold_ready", 32'(op_ready), 32'd0);
            check("hold_res_d", 32'(res_d), 32'(er));
            @(negedge clk);
        end
        check("res_d", 32'(res_d), 32'(er));
        check("res_carry", 32'(res_carry), 32'(ec));
        check("res_zero", 32'(res_zero), 32'(ez));
        check("res_equ", 32'(res_equ), 32'(ee));
        check("sl_idle_done", 32'({sl_a, sl_b, sl_f, sl_com, sl_ci_right, sl_ci_left}), 32'd0);
        op_valid  = 1'b0;
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        check("xfer_valid", 32'(res_valid), 32'd0);
        check("xfer_ready", 32'(op_ready), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n     = 1'b0;
        op_valid  = 1'b0;
        op_a      = 16'h0;
        op_b      = 16'h0;
        op_fn     = 3'd0;
        op_com    = 1'b0;
        op_cin    = 1'b0;
        res_ready = 1'b0;
        #3;
        check("rst_ready", 32'(op_ready), 32'd0);
        check("rst_valid", 32'(res_valid), 32'd0);
        check("rst_res", 32'({res_d, res_carry, res_zero, res_equ}), 32'd0);
        check("rst_sl", 32'({sl_a, sl_b, sl_f, sl_com, sl_ci_right, sl_ci_left}), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("post_rst_ready", 32'(op_ready), 32'd1);
        @(negedge clk);

        run_op(3'd0, 16'h0FFF, 16'h0001, 1'b0, 1'b0, 0);
        run_op(3'd0, 16'hFFFF, 16'h0001, 1'b0, 1'b0, 1);
        run_op(3'd7, 16'h8001, 16'h0000, 1'b0, 1'b0, 0);
        run_op(3'd6, 16'h8001, 16'h0000, 1'b0, 1'b1, 0);
        run_op(3'd3, 16'h1234, 16'h1234, 1'b1, 1'b0, 0);
        run_op(3'd1, 16'hA5C3, 16'h3C5A, 1'b0, 1'b0, 5);

        // Reset in the middle of pass 2 of an ADD.
        op_valid = 1'b1;
        op_fn    = 3'd0;
        op_a     = 16'h1357;
        op_b     = 16'h2468;
        op_com   = 1'b0;
        op_cin   = 1'b1;
        @(negedge clk);
        op_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("mid_sl_a", 32'(sl_a), 32'h3);
        rst_n = 1'b0;
        #1;
        check("mid_rst_ready", 32'(op_ready), 32'd0);
        check("mid_rst_valid", 32'(res_valid), 32'd0);
        check("mid_rst_res", 32'({res_d, res_carry, res_zero, res_equ}), 32'd0);
        check("mid_rst_sl", 32'({sl_a, sl_b, sl_f, sl_com, sl_ci_right, sl_ci_left}), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("mid_post_valid", 32'(res_valid), 32'd0);
        run_op(3'd0, 16'h1357, 16'h2468, 1'b0, 1'b1, 0);

        for (int k = 0; k < 40; k++) begin
            logic [15:0] ra;
            logic [15:0] rb;
            ra = 16'($urandom);
            rb = ($urandom_range(0, 3) == 0) ? ra : 16'($urandom);
            run_op(3'($urandom), ra, rb, 1'($urandom), 1'($urandom), $urandom_range(0, 3));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
